// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM state
// encoding, digit-select codes, per-digit BCD limits and small digit helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        ADJUST = 2'd3
    } state_t;

    localparam logic [2:0] SEL_MIN_L = 3'd0;
    localparam logic [2:0] SEL_MIN_R = 3'd1;
    localparam logic [2:0] SEL_SEC_L = 3'd2;
    localparam logic [2:0] SEL_SEC_R = 3'd3;

    localparam logic [3:0] LIMIT_MIN_L = 4'd9;
    localparam logic [3:0] LIMIT_MIN_R = 4'd9;
    localparam logic [3:0] LIMIT_SEC_L = 4'd5;
    localparam logic [3:0] LIMIT_SEC_R = 4'd9;

    // Pick one BCD digit out of {min_l,min_r,sec_l,sec_r}
    function automatic logic [3:0] digit_of(logic [15:0] digits, logic [2:0] sel);
        case (sel)
            SEL_MIN_L: return digits[15:12];
            SEL_MIN_R: return digits[11:8];
            SEL_SEC_L: return digits[7:4];
            default:   return digits[3:0];
        endcase
    endfunction

    function automatic logic [3:0] limit_of(logic [2:0] sel);
        case (sel)
            SEL_MIN_L: return LIMIT_MIN_L;
            SEL_MIN_R: return LIMIT_MIN_R;
            SEL_SEC_L: return LIMIT_SEC_L;
            default:   return LIMIT_SEC_R;
        endcase
    endfunction

    // Increment with wrap; anything at or beyond the limit (including junk) goes to 0
    function automatic logic [3:0] digit_next(logic [3:0] d, logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    // Selection walks 3 -> 2 -> 1 -> 0 -> 3
    function automatic logic [2:0] sel_step(logic [2:0] sel);
        return (sel == SEL_MIN_L) ? SEL_SEC_R : sel - 3'd1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/level inputs and control outputs of the stopwatch controller.
// master = button/time-counter side, slave = the controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic        btn_pause;
    logic        btn_clear;
    logic        adj_mode;
    logic        btn_sel;
    logic        btn_inc;
    logic [15:0] digits;
    logic        tick;
    logic        paused;
    logic        clr;
    logic [2:0]  adj_sel;
    logic [3:0]  adj_val;
    logic        adj_load;
    logic        blink;
    state_t      state;

    modport master (
        output btn_pause, btn_clear, adj_mode, btn_sel, btn_inc, digits,
        input  tick, paused, clr, adj_sel, adj_val, adj_load, blink, state
    );

    modport slave (
        input  btn_pause, btn_clear, adj_mode, btn_sel, btn_inc, digits,
        output tick, paused, clr, adj_sel, adj_val, adj_load, blink, state
    );

endinterface

// File: rtl/stopwatch_prescaler.sv
// Free-running modulo-DIV counter that only advances while enabled and
// flags its terminal count with a single-cycle pulse.
module stopwatch_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pulse
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // Count 0..DIV-1 while enabled, hold otherwise, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign pulse = en && !clr && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/clear FSM, tick prescaler and an
// optional digit-adjust mode. Define STOPWATCH_ADJ_EN to build the ADJUST
// state with its digit select/increment and blink logic; without it the
// adjust outputs are tied to their idle values.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave sw
);
    state_t state_q, state_d;
    logic   tick_en, tick_clr, tick_pulse;
    logic   blink_en, blink_clr, blink_pulse;
    logic   clr_q;

    // A clear suppresses counting in its own cycle; IDLE keeps the tick count at zero
    assign tick_en   = (state_q == RUN) && !sw.btn_clear;
    assign tick_clr  = sw.btn_clear || (state_q == IDLE);
    assign blink_en  = (state_q == ADJUST) && !sw.btn_clear;
    assign blink_clr = sw.btn_clear || (state_q != ADJUST);

    stopwatch_prescaler #(.DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .pulse (tick_pulse)
    );

    stopwatch_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (blink_en),
        .clr   (blink_clr),
        .pulse (blink_pulse)
    );

    // Next-state decode; clear overrides every other input
    always_comb begin
        state_d = state_q;
        if (sw.btn_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sw.btn_pause) state_d = RUN;
`ifdef STOPWATCH_ADJ_EN
                    else if (sw.adj_mode) state_d = ADJUST;
`endif
                end
                RUN: begin
                    if (sw.btn_pause) state_d = PAUSE;
                end
                PAUSE: begin
                    if (sw.btn_pause) state_d = RUN;
`ifdef STOPWATCH_ADJ_EN
                    else if (sw.adj_mode) state_d = ADJUST;
`endif
                end
                ADJUST: begin
`ifdef STOPWATCH_ADJ_EN
                    if (!sw.adj_mode) state_d = PAUSE;
`else
                    state_d = PAUSE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and the one-cycle clear strobe to the time counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= sw.btn_clear;
        end
    end

    assign sw.state  = state_q;
    assign sw.paused = (state_q != RUN);
    assign sw.tick   = tick_pulse;
    assign sw.clr    = clr_q;

`ifdef STOPWATCH_ADJ_EN
    logic [2:0] adj_sel_q;
    logic [3:0] adj_val_q;
    logic       adj_load_q;
    logic       blink_q;
    logic       adj_entry;
    logic       adj_inc;

    assign adj_entry = (state_q != ADJUST) && (state_d == ADJUST);
    assign adj_inc   = (state_q == ADJUST) && sw.btn_inc && !sw.btn_clear;

    // Digit select and write strobe; increment uses the selection before any step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_sel_q  <= SEL_SEC_R;
            adj_val_q  <= 4'd0;
            adj_load_q <= 1'b0;
        end else begin
            adj_load_q <= adj_inc;
            if (adj_inc) begin
                adj_val_q <= digit_next(digit_of(sw.digits, adj_sel_q), limit_of(adj_sel_q));
            end
            if (adj_entry) begin
                adj_sel_q <= SEL_SEC_R;
            end else if ((state_q == ADJUST) && sw.btn_sel && !sw.btn_clear) begin
                adj_sel_q <= sel_step(adj_sel_q);
            end
        end
    end

    // Blink starts high on entry, toggles on each blink terminal count, low elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else if (state_d != ADJUST) begin
            blink_q <= 1'b0;
        end else if (adj_entry) begin
            blink_q <= 1'b1;
        end else if (blink_pulse) begin
            blink_q <= !blink_q;
        end
    end

    assign sw.adj_sel  = adj_sel_q;
    assign sw.adj_val  = adj_val_q;
    assign sw.adj_load = adj_load_q;
    assign sw.blink    = blink_q;
`else
    logic unused_adj;
    assign unused_adj  = ^{sw.adj_mode, sw.btn_sel, sw.btn_inc, sw.digits, blink_pulse};

    assign sw.adj_sel  = SEL_SEC_R;
    assign sw.adj_val  = 4'd0;
    assign sw.adj_load = 1'b0;
    assign sw.blink    = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV SHALL default to 100000000; clk cycles per tick pulse (1 Hz at 100 MHz).
REQ-002 Parameter BLINK_DIV SHALL default to 25000000; clk cycles per blink toggle.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 btn_pause  in  1  one-cycle pulse, pre-debounced; start/pause toggle.
REQ-006 btn_clear  in  1  one-cycle pulse; clear time to 00:00.
REQ-007 adj_mode  in  1  level switch; request adjust mode.
REQ-008 btn_sel  in  1  one-cycle pulse; advance adjusted digit.
REQ-009 btn_inc  in  1  one-cycle pulse; increment adjusted digit.
REQ-010 digits  in  16  current time, {min_l,min_r,sec_l,sec_r}, 4 bits each, BCD.
REQ-011 tick  out  1  one-cycle count enable to the time counter.
REQ-012 paused  out  1  high whenever state is not RUN.
REQ-013 clr  out  1  one-cycle synchronous clear to the time counter.
REQ-014 adj_sel  out  3  digit select: 0 min_l, 1 min_r, 2 sec_l, 3 sec_r.
REQ-015 adj_val  out  4  value to write into the selected digit.
REQ-016 adj_load  out  1  one-cycle write strobe for adj_sel/adj_val.
REQ-017 blink  out  1  square wave for flashing the selected digit; low outside ADJUST.
REQ-018 state  out  2  current FSM state, encoded per stopwatch_pkg.

Function
REQ-019 FSM states SHALL be IDLE, RUN, PAUSE and ADJUST.
REQ-020 IDLE--btn_pause-->RUN; RUN--btn_pause-->PAUSE; PAUSE--btn_pause-->RUN.
REQ-021 btn_clear in any state SHALL pulse clr the next cycle, enter IDLE, and zero both prescalers.
REQ-022 btn_clear SHALL take priority over every other input in the same cycle.
REQ-023 adj_mode high SHALL enter ADJUST from IDLE or PAUSE only; in RUN it SHALL be ignored until the FSM leaves RUN.
REQ-024 adj_mode low in ADJUST SHALL return the FSM to PAUSE; btn_pause in ADJUST SHALL be ignored.
REQ-025 Tick prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE/ADJUST, and stay zero in IDLE.
REQ-026 tick SHALL be high for exactly the one cycle in which the prescaler is at TICK_DIV-1 in RUN, after which the prescaler wraps to 0.
REQ-027 Pause and resume SHALL NOT lose the partial second: total RUN cycles between ticks SHALL equal TICK_DIV.
REQ-028 On ADJUST entry, adj_sel SHALL be 3; btn_sel SHALL step it 3->2->1->0->3.
REQ-029 btn_inc in ADJUST SHALL pulse adj_load on the next cycle, with adj_val = selected digit + 1, wrapping to 0 past its limit.
REQ-030 Digit limits SHALL be 9 for min_l, min_r and sec_r, and 5 for sec_l.
REQ-031 An out-of-range input digit on btn_inc SHALL yield adj_val 0.
REQ-032 If btn_sel and btn_inc coincide, the increment SHALL apply to the pre-step adj_sel, and adj_sel SHALL step in the same cycle.
REQ-033 blink SHALL toggle every BLINK_DIV cycles in ADJUST and restart high on each ADJUST entry.

Reset
REQ-034 On rst_n low: state=IDLE, tick=0, paused=1, clr=0, adj_sel=3, adj_val=0, adj_load=0, blink=0, and both prescalers=0.
REQ-035 Reset assertion mid-operation SHALL abort any pending pulse; no output pulse SHALL occur in the first cycle after release.

Configuration
REQ-036 With STOPWATCH_ADJ_EN defined, ADJUST and the btn_sel/btn_inc/blink logic SHALL be present.
REQ-037 Without STOPWATCH_ADJ_EN, ADJUST SHALL be unreachable, adj_load/blink SHALL be held 0, adj_sel SHALL be held 3, adj_val SHALL be held 0, and all ports SHALL remain present.

Structure
REQ-038 stopwatch_pkg SHALL hold the state enum, the digit-select codes 0-3, and the digit-limit constants.
REQ-039 The sub-module stopwatch_prescaler (parameter DIV; en, clr inputs; terminal-count pulse output) SHALL be instantiated once for tick and once for blink.

Verification (TICK_DIV=4, BLINK_DIV=2)
REQ-040 Reset release, btn_pause -> state RUN; tick every 4th cycle; paused=0.
REQ-041 RUN for 2 cycles, pause for 10 cycles, resume -> next tick 2 RUN cycles after resume.
REQ-042 In RUN, btn_clear and btn_pause in the same cycle -> clr pulses once; state IDLE; no tick.
REQ-043 In PAUSE, adj_mode=1, btn_sel x1, digits sec_l=5, btn_inc -> adj_sel=2, adj_val=0, adj_load pulses one cycle.
REQ-044 In RUN, adj_mode=1 -> state stays RUN; after btn_pause -> ADJUST with blink toggling every 2 cycles.
REQ-045 Built without STOPWATCH_ADJ_EN, in PAUSE: adj_mode=1 and btn_inc -> state stays PAUSE and adj_load stays 0.
